x_play: RTL and testbench

- Playback sequencer for the DAC path.
- Reads stored samples from the sample memory and presents one 6-bit binary code per sample period to the binary-to-thermometer stage.
- Shares the memory's single port with the UART command controller through a request/grant handshake; the controller always has priority.
- Supports one-shot and looped playback of an address window, with underrun detection.

---
 rtl/x_play_pkg.sv | 23 ++
 rtl/x_play_div.sv | 35 +++
 rtl/x_play.sv | 140 ++++++++++++++
 tb/tb_x_play.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/x_play_pkg.sv
// ----------------------------------------------------------------------------
// x_play_pkg : shared types and defaults for the DAC playback sequencer
// Revision   : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package x_play_pkg;

  localparam int DEF_AW   = 11;
  localparam int DEF_DW   = 6;
  localparam int DEF_DIVW = 16;
  localparam int MIN_DIV  = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    LAT   = 2'd2,
    READY = 2'd3
  } state_t;

endpackage

`default_nettype wire

// File: rtl/x_play_div.sv
// ----------------------------------------------------------------------------
// x_play_div : reloadable down-counter producing the sample-period tick
// Revision   : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module x_play_div #(
  parameter int DIVW = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic [DIVW-1:0] div_eff,
  input  logic            enable,
  output logic            tick
);

  logic [DIVW-1:0] cnt;

  // Counts div_eff..0, so the period is div_eff+1 clocks.
  assign tick = enable && (cnt == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load || tick) begin
      cnt <= div_eff;
    end else if (enable) begin
      cnt <= cnt - 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/x_play.sv
// ----------------------------------------------------------------------------
// x_play   : playback sequencer feeding one sample per period to the DAC path
// Revision : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module x_play
  import x_play_pkg::*;
#(
  parameter int AW   = DEF_AW,
  parameter int DW   = DEF_DW,
  parameter int DIVW = DEF_DIVW
) (
  input  logic            i_clk,
  input  logic            i_nrst,
  input  logic            i_start,
  input  logic            i_stop,
  input  logic            i_loop,
  input  logic [AW-1:0]   i_start_addr,
  input  logic [AW-1:0]   i_end_addr,
  input  logic [DIVW-1:0] i_div,
  output logic            o_rd_req,
  output logic [AW-1:0]   o_addr,
  input  logic            i_rd_gnt,
  input  logic [DW-1:0]   i_rdata,
  output logic [DW-1:0]   o_bin,
  output logic            o_strobe,
  output logic            o_busy,
  output logic            o_done,
  output logic            o_underrun
);

  localparam logic [DIVW-1:0] MIN_DIV_W = DIVW'(MIN_DIV);

  state_t          state;
  state_t          state_nx;
  logic [AW-1:0]   addr;
  logic [AW-1:0]   start_q;
  logic [AW-1:0]   end_q;
  logic [DIVW-1:0] div_q;
  logic            loop_q;
  logic [DW-1:0]   buf_q;
  logic [DW-1:0]   bin_q;
  logic            strobe_q;
  logic            done_q;
  logic            under_q;

  logic            start_acc;
  logic            busy;
  logic            tick;
  logic            at_end;
  logic [DIVW-1:0] div_clamp;
  logic [DIVW-1:0] div_sel;

  assign busy      = (state != IDLE);
  assign start_acc = (state == IDLE) && i_start && !i_stop;
  assign at_end    = (addr == end_q);
  assign div_clamp = (i_div < MIN_DIV_W) ? MIN_DIV_W : i_div;
  // The counter loads the fresh divider on start, the captured one on reload.
  assign div_sel   = start_acc ? div_clamp : div_q;

  x_play_div #(
    .DIVW (DIVW)
  ) u_div (
    .clk     (i_clk),
    .rst_n   (i_nrst),
    .load    (start_acc),
    .div_eff (div_sel),
    .enable  (busy),
    .tick    (tick)
  );

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start_acc) state_nx = FETCH;
      FETCH:   if (i_rd_gnt)  state_nx = LAT;
      LAT:     state_nx = READY;
      READY:   if (tick) state_nx = (at_end && !loop_q) ? IDLE : FETCH;
      default: state_nx = IDLE;
    endcase
    if (i_stop) state_nx = IDLE;
  end

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      state    <= IDLE;
      addr     <= '0;
      start_q  <= '0;
      end_q    <= '0;
      div_q    <= '0;
      loop_q   <= 1'b0;
      buf_q    <= '0;
      bin_q    <= '0;
      strobe_q <= 1'b0;
      done_q   <= 1'b0;
      under_q  <= 1'b0;
    end else begin
      state    <= state_nx;
      strobe_q <= 1'b0;
      done_q   <= 1'b0;
      under_q  <= 1'b0;
      if (start_acc) begin
        start_q <= i_start_addr;
        end_q   <= i_end_addr;
        div_q   <= div_clamp;
        loop_q  <= i_loop;
        addr    <= i_start_addr;
      end
      // A stop freezes the output and discards any in-flight sample.
      if (!i_stop) begin
        if (state == LAT) buf_q <= i_rdata;
        if (tick) begin
          case (state)
            READY: begin
              bin_q    <= buf_q;
              strobe_q <= 1'b1;
              if (!at_end)     addr   <= addr + 1'b1;
              else if (loop_q) addr   <= start_q;
              else             done_q <= 1'b1;
            end
            FETCH, LAT: under_q <= 1'b1;
            default: ;
          endcase
        end
      end
    end
  end

  assign o_rd_req   = (state == FETCH);
  assign o_addr     = addr;
  assign o_bin      = bin_q;
  assign o_strobe   = strobe_q;
  assign o_busy     = busy;
  assign o_done     = done_q;
  assign o_underrun = under_q;

endmodule

`default_nettype wire

// File: tb/tb_x_play.sv
// ----------------------------------------------------------------------------
// tb_x_play : directed scoreboard bench for the x_play playback sequencer
// Revision  : 1.0
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_x_play;

  localparam int AW   = 11;
  localparam int DW   = 6;
  localparam int DIVW = 16;

  logic            clk = 1'b0;
  logic            nrst;
  logic            start;
  logic            stop;
  logic            loop;
  logic [AW-1:0]   start_addr;
  logic [AW-1:0]   end_addr;
  logic [DIVW-1:0] div;
  logic            rd_req;
  logic [AW-1:0]   addr;
  logic            gnt;
  logic [DW-1:0]   rdata = '0;
  logic [DW-1:0]   bin;
  logic            strobe;
  logic            busy;
  logic            done;
  logic            underrun;

  logic [DW-1:0]   mem [0:(1<<AW)-1];

  typedef struct {
    logic [DW-1:0] bin;
    logic          done;
    int            gap;
  } exp_t;

  exp_t          sb[$];
  exp_t          mon_e;
  int            tests       = 0;
  int            fails       = 0;
  int            cyc         = 0;
  int            last_strobe = 0;
  int            und_cnt     = 0;
  int            u0;
  logic [DW-1:0] held;

  always #5 clk = ~clk;

  x_play #(
    .AW   (AW),
    .DW   (DW),
    .DIVW (DIVW)
  ) dut (
    .i_clk        (clk),
    .i_nrst       (nrst),
    .i_start      (start),
    .i_stop       (stop),
    .i_loop       (loop),
    .i_start_addr (start_addr),
    .i_end_addr   (end_addr),
    .i_div        (div),
    .o_rd_req     (rd_req),
    .o_addr       (addr),
    .i_rd_gnt     (gnt),
    .i_rdata      (rdata),
    .o_bin        (bin),
    .o_strobe     (strobe),
    .o_busy       (busy),
    .o_done       (done),
    .o_underrun   (underrun)
  );

  // Single-port memory: data appears the cycle after an accepted read.
  always @(posedge clk) begin
    if (rd_req && gnt) rdata <= mem[addr];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard consumer: every strobe pops one expected sample.
  always @(posedge clk) begin
    cyc++;
    #2;
    if (nrst === 1'b1) begin
      if (underrun === 1'b1) und_cnt++;
      if (strobe === 1'b1) begin
        check("strobe_expected", 32'(sb.size() > 0), 32'd1);
        if (sb.size() > 0) begin
          mon_e = sb.pop_front();
          check("bin", 32'(bin), 32'(mon_e.bin));
          check("done_with_strobe", 32'(done), 32'(mon_e.done));
          if (mon_e.gap != 0) check("period", cyc - last_strobe, mon_e.gap);
        end
        last_strobe = cyc;
      end
    end
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [DW-1:0] b, input logic d, input int g);
    exp_t e;
    e.bin  = b;
    e.done = d;
    e.gap  = g;
    sb.push_back(e);
  endtask

  task automatic begin_play(input logic [AW-1:0] sa, input logic [AW-1:0] ea,
                            input logic [DIVW-1:0] dv, input logic lp);
    start_addr = sa;
    end_addr   = ea;
    div        = dv;
    loop       = lp;
    start      = 1'b1;
    step;
    start      = 1'b0;
  endtask

  task automatic wait_done(input int bound);
    int n = 0;
    while (done !== 1'b1 && n < bound) begin
      step;
      n++;
    end
    check("done_seen", 32'(done), 32'd1);
    check("busy_at_done", 32'(busy), 32'd0);
    step;
    check("done_pulse", 32'(done), 32'd0);
    check("sb_drained", sb.size(), 32'd0);
  endtask

  task automatic wait_drain(input int bound);
    int n = 0;
    while (sb.size() != 0 && n < bound) begin
      step;
      n++;
    end
    check("drain", sb.size(), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    nrst = 1'b0; start = 1'b0; stop = 1'b0; loop = 1'b0;
    start_addr = '0; end_addr = '0; div = '0; gnt = 1'b1;
    for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
    mem[10] = 6'd5;  mem[11] = 6'd17; mem[12] = 6'd40; mem[13] = 6'd63;
    mem[2046] = 6'd1; mem[2047] = 6'd2; mem[0] = 6'd3; mem[1] = 6'd4;

    repeat (2) step;
    check("reset_outs", 32'({bin, strobe, busy, done, underrun, rd_req, addr}), 32'd0);
    nrst = 1'b1;
    step;

    // One-shot, div=4
    push(6'd5, 1'b0, 0); push(6'd17, 1'b0, 5); push(6'd40, 1'b0, 5); push(6'd63, 1'b1, 5);
    begin_play(11'd10, 11'd13, 16'd4, 1'b0);
    repeat (4) step;
    check("lat_early", 32'(strobe), 32'd0);
    step;
    check("lat_strobe", 32'(strobe), 32'd1);
    check("lat_bin", 32'(bin), 32'd5);
    wait_done(40);

    // Looped playback across the address wrap, then stop
    u0 = und_cnt;
    push(6'd1, 1'b0, 0); push(6'd2, 1'b0, 3); push(6'd3, 1'b0, 3);
    push(6'd4, 1'b0, 3); push(6'd1, 1'b0, 3); push(6'd2, 1'b0, 3);
    begin_play(11'd2046, 11'd1, 16'd2, 1'b1);
    wait_drain(60);
    check("loop_no_underrun", und_cnt, u0);
    held = bin;
    stop = 1'b1;
    step;
    stop = 1'b0;
    check("stop_busy", 32'(busy), 32'd0);
    check("stop_bin_hold", 32'(bin), 32'(held));
    check("stop_req", 32'(rd_req), 32'd0);
    repeat (6) step;
    check("stop_idle_hold", 32'({busy, bin}), 32'({1'b0, held}));

    // Divider clamp: div=0 behaves as div=2
    u0 = und_cnt;
    push(6'd5, 1'b0, 0); push(6'd17, 1'b0, 3); push(6'd40, 1'b0, 3); push(6'd63, 1'b1, 3);
    begin_play(11'd10, 11'd13, 16'd0, 1'b0);
    wait_done(30);
    check("clamp_no_underrun", und_cnt, u0);

    // Grant starvation across the second fetch
    u0 = und_cnt;
    push(6'd5, 1'b0, 0); push(6'd17, 1'b0, 8); push(6'd40, 1'b0, 4); push(6'd63, 1'b1, 4);
    begin_play(11'd10, 11'd13, 16'd3, 1'b0);
    repeat (2) step;
    gnt = 1'b0;
    repeat (6) step;
    check("starve_underrun", 32'(underrun), 32'd1);
    check("starve_bin_hold", 32'(bin), 32'd5);
    check("starve_no_strobe", 32'(strobe), 32'd0);
    gnt = 1'b1;
    wait_done(30);
    check("starve_one_underrun", und_cnt, u0 + 1);

    // Start and stop together
    start_addr = 11'd10; end_addr = 11'd13; div = 16'd4; loop = 1'b0;
    start = 1'b1; stop = 1'b1;
    step;
    start = 1'b0; stop = 1'b0;
    check("start_stop_idle", 32'(busy), 32'd0);
    step;
    check("start_stop_req", 32'(rd_req), 32'd0);

    // Start while busy is ignored and config changes do not take effect
    push(6'd5, 1'b0, 0); push(6'd17, 1'b0, 5); push(6'd40, 1'b0, 5); push(6'd63, 1'b1, 5);
    begin_play(11'd10, 11'd13, 16'd4, 1'b0);
    repeat (3) step;
    start_addr = 11'd2046; end_addr = 11'd1; div = 16'd2; loop = 1'b1;
    start = 1'b1;
    step;
    start = 1'b0;
    wait_done(40);

    // Asynchronous reset while in LAT
    begin_play(11'd10, 11'd13, 16'd4, 1'b0);
    step;
    check("pre_reset_lat", 32'({rd_req, busy}), 32'd1);
    #2 nrst = 1'b0;
    #1;
    check("reset_async", 32'({bin, strobe, busy, done, underrun, rd_req, addr}), 32'd0);
    repeat (2) step;
    nrst = 1'b1;
    step;

    push(6'd40, 1'b0, 0); push(6'd63, 1'b1, 3);
    begin_play(11'd12, 11'd13, 16'd2, 1'b0);
    repeat (2) step;
    check("post_reset_early", 32'(strobe), 32'd0);
    step;
    check("post_reset_strobe", 32'({strobe, bin}), 32'({1'b1, 6'd40}));
    wait_done(20);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
